// File: rtl/write_buffer_coalesce.sv
// Posted-write buffer between the data cache and the memory arbiter.
// Entries drain in allocation order; writes to an already-buffered unlocked address merge by byte lane.
module write_buffer_coalesce #(
  parameter int DEPTH    = 4,
  parameter int AW       = 30,
  parameter int DW       = 32,
  parameter int COALESCE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [AW-1:0]              wr_adr,
  input  logic [DW-1:0]              wr_data,
  input  logic [DW/8-1:0]            wr_byteen,
  input  logic                       wr_en,
  output logic                       wr_ack,
  input  logic [AW-1:0]              lk_adr,
  output logic                       lk_hit,
  output logic [DW-1:0]              lk_data,
  output logic [DW/8-1:0]            lk_byteen,
  output logic [AW-1:0]              mem_adr,
  output logic [DW-1:0]              mem_data,
  output logic [DW/8-1:0]            mem_byteen,
  output logic                       mem_en,
  input  logic                       mem_done,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int NB = DW / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  logic [AW-1:0]    r_adr    [DEPTH];
  logic [DW-1:0]    r_data   [DEPTH];
  logic [NB-1:0]    r_byteen [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_mem_adr;
  logic [DW-1:0]    r_mem_data;
  logic [NB-1:0]    r_mem_byteen;

  logic             w_full;
  logic             w_locked;
  logic             w_zero;
  logic             w_hit;
  logic [PW-1:0]    w_hit_idx;
  logic             w_do_coal;
  logic             w_do_alloc;
  logic             w_wr;
  logic [PW-1:0]    w_wr_idx;
  logic [DW-1:0]    w_merged_data;
  logic [NB-1:0]    w_merged_byteen;
  logic [DW-1:0]    w_wr_data;
  logic [NB-1:0]    w_wr_byteen;
  logic             w_retire;
  logic [PW-1:0]    w_next_head;
  logic             w_load;
  logic [PW-1:0]    w_load_idx;
  logic             w_load_bypass;
  logic [DW-1:0]    w_load_data;
  logic [NB-1:0]    w_load_byteen;
  logic [PW-1:0]    w_lk_idx;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_locked = (r_state == S_BUSY);
  assign w_zero   = ~|wr_byteen;

  // The head is locked while it sits on mem_*, so it is never a merge target.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_adr[i] == wr_adr) && !(w_locked && (PW'(i) == r_head))) begin
        w_hit     = 1'b1;
        w_hit_idx = PW'(i);
      end
    end
  end

  always_comb begin
    w_merged_data   = r_data[w_hit_idx];
    w_merged_byteen = r_byteen[w_hit_idx] | wr_byteen;
    for (int b = 0; b < NB; b++) begin
      if (wr_byteen[b]) w_merged_data[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  assign w_do_coal  = wr_en && !w_zero && (COALESCE != 0) && w_hit;
  assign w_do_alloc = wr_en && !w_zero && !w_do_coal && !w_full;
  assign wr_ack     = wr_en && (w_zero || w_do_coal || !w_full);
  assign w_wr       = w_do_coal || w_do_alloc;
  assign w_wr_idx   = w_do_coal ? w_hit_idx : r_tail;
  assign w_wr_data  = w_do_coal ? w_merged_data : wr_data;
  assign w_wr_byteen = w_do_coal ? w_merged_byteen : wr_byteen;

  assign w_retire    = w_locked && mem_done;
  assign w_next_head = r_head + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_idx  = r_head;
    case (r_state)
      S_IDLE: begin
        if (r_valid[r_head]) begin
          w_load      = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (mem_done) begin
          if (r_valid[w_next_head]) begin
            w_load     = 1'b1;
            w_load_idx = w_next_head;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A merge into the entry being loaded this edge must reach memory, so bypass it.
  assign w_load_bypass = w_do_coal && (w_hit_idx == w_load_idx);
  assign w_load_data   = w_load_bypass ? w_merged_data : r_data[w_load_idx];
  assign w_load_byteen = w_load_bypass ? w_merged_byteen : r_byteen[w_load_idx];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_state      <= S_IDLE;
      r_mem_adr    <= '0;
      r_mem_data   <= '0;
      r_mem_byteen <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= w_next_head;
      end
      if (w_do_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      case ({w_do_alloc, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_load) begin
        r_mem_adr    <= r_adr[w_load_idx];
        r_mem_data   <= w_load_data;
        r_mem_byteen <= w_load_byteen;
      end
    end
  end

  // NOTE: entry payload has no reset; r_valid gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_adr[w_wr_idx]    <= wr_adr;
      r_data[w_wr_idx]   <= w_wr_data;
      r_byteen[w_wr_idx] <= w_wr_byteen;
    end
  end

  // Walk from oldest to youngest so younger entries overwrite older lanes.
  always_comb begin
    lk_hit    = 1'b0;
    lk_data   = '0;
    lk_byteen = '0;
    w_lk_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_lk_idx = r_head + PW'(k);
      if (r_valid[w_lk_idx] && (r_adr[w_lk_idx] == lk_adr)) begin
        lk_hit = 1'b1;
        for (int b = 0; b < NB; b++) begin
          if (r_byteen[w_lk_idx][b]) begin
            lk_data[8*b +: 8] = r_data[w_lk_idx][8*b +: 8];
            lk_byteen[b]      = 1'b1;
          end
        end
      end
    end
  end

  assign mem_adr    = r_mem_adr;
  assign mem_data   = r_mem_data;
  assign mem_byteen = r_mem_byteen;
  assign mem_en     = (r_state == S_BUSY);
  assign full       = w_full;
  assign empty      = (r_count == '0);
  assign count      = r_count;

endmodule

// File: tb/tb_write_buffer_coalesce.sv
// Self-checking bench for write_buffer_coalesce: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_write_buffer_coalesce;

  localparam int DEPTH = 4;
  localparam int AW    = 30;
  localparam int DW    = 32;
  localparam int NB    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] wr_adr;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] wr_byteen;
  logic          wr_en;
  logic          wr_ack;
  logic [AW-1:0] lk_adr;
  logic          lk_hit;
  logic [DW-1:0] lk_data;
  logic [NB-1:0] lk_byteen;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_data;
  logic [NB-1:0] mem_byteen;
  logic          mem_en;
  logic          mem_done;
  logic          full;
  logic          empty;
  logic [2:0]    count;

  int n_checks = 0;
  int n_errors = 0;

  write_buffer_coalesce #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .COALESCE(1)) dut (
    .clk(clk), .reset(reset),
    .wr_adr(wr_adr), .wr_data(wr_data), .wr_byteen(wr_byteen), .wr_en(wr_en), .wr_ack(wr_ack),
    .lk_adr(lk_adr), .lk_hit(lk_hit), .lk_data(lk_data), .lk_byteen(lk_byteen),
    .mem_adr(mem_adr), .mem_data(mem_data), .mem_byteen(mem_byteen), .mem_en(mem_en),
    .mem_done(mem_done), .full(full), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  // Reference model: pending writes in age order, plus the in-flight memory request.
  typedef struct {
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
    logic [NB-1:0] be;
  } ent_t;

  ent_t          q[$];
  bit            m_busy;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_data;
  logic [NB-1:0] m_be;

  function automatic int find_unlocked(logic [AW-1:0] a);
    int j = -1;
    for (int k = 0; k < q.size(); k++)
      if (q[k].adr == a && !(m_busy && k == 0)) j = k;
    return j;
  endfunction

  function automatic bit model_ack();
    if (!wr_en) return 1'b0;
    if (wr_byteen == '0) return 1'b1;
    if (find_unlocked(wr_adr) >= 0) return 1'b1;
    return q.size() < DEPTH;
  endfunction

  function automatic void model_lookup(input logic [AW-1:0] a, output bit hit,
                                       output logic [DW-1:0] d, output logic [NB-1:0] be);
    hit = 1'b0;
    d   = '0;
    be  = '0;
    for (int k = 0; k < q.size(); k++) begin
      if (q[k].adr == a) begin
        hit = 1'b1;
        for (int b = 0; b < NB; b++)
          if (q[k].be[b]) begin
            d[8*b +: 8] = q[k].data[8*b +: 8];
            be[b]       = 1'b1;
          end
      end
    end
  endfunction

  function automatic logic [DW-1:0] lane_mask(logic [NB-1:0] be);
    logic [DW-1:0] m = '0;
    for (int b = 0; b < NB; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic model_reset();
    q.delete();
    m_busy = 1'b0;
    m_adr  = '0;
    m_data = '0;
    m_be   = '0;
  endtask

  task automatic model_load();
    m_busy = 1'b1;
    m_adr  = q[0].adr;
    m_data = q[0].data;
    m_be   = q[0].be;
  endtask

  // Advance the model by one edge using the currently driven inputs, then let the DUT take the edge.
  task automatic tick();
    int   j;
    int   pre;
    bit   retire;
    ent_t e;
    pre    = q.size();
    retire = m_busy && mem_done;
    if (wr_en && wr_byteen != '0) begin
      j = find_unlocked(wr_adr);
      if (j >= 0) begin
        e = q[j];
        for (int b = 0; b < NB; b++) if (wr_byteen[b]) e.data[8*b +: 8] = wr_data[8*b +: 8];
        e.be = e.be | wr_byteen;
        q[j] = e;
      end else if (q.size() < DEPTH) begin
        e.adr  = wr_adr;
        e.data = wr_data;
        e.be   = wr_byteen;
        q.push_back(e);
      end
    end
    if (retire) void'(q.pop_front());
    if (!m_busy) begin
      if (pre > 0) model_load();
    end else if (retire) begin
      if (pre > 1) model_load();
      else m_busy = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(bit we, logic [AW-1:0] a, logic [DW-1:0] d, logic [NB-1:0] be, bit done);
    @(negedge clk);
    wr_en     = we;
    wr_adr    = a;
    wr_data   = d;
    wr_byteen = be;
    mem_done  = done;
    #1;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      set_in(1'b0, '0, '0, '0, 1'b1);
      tick();
      if (q.size() == 0 && !m_busy) ok = 1'b1;
    end
    set_in(1'b0, '0, '0, '0, 1'b0);
    n_checks++;
    if (!ok || empty !== 1'b1 || mem_en !== 1'b0) begin
      n_errors++;
      $display("FAIL drain: empty=%0b mem_en=%0b model_done=%0b, required empty=1 mem_en=0", empty, mem_en, ok);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wr_en = 1'b0; wr_adr = '0; wr_data = '0; wr_byteen = '0; lk_adr = '0; mem_done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({mem_en, mem_adr, mem_data, mem_byteen} !== '0) begin
      n_errors++;
      $display("FAIL reset_mem: en=%0b adr=%h data=%h be=%b, required all zero", mem_en, mem_adr, mem_data, mem_byteen);
    end
    n_checks++;
    if ({count, empty, full} !== {3'd0, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_status: count=%0d empty=%0b full=%0b, required 0/1/0", count, empty, full);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    set_in(1'b1, 30'h4AD, 32'hDDCCBBAA, 4'hF, 1'b0);
    n_checks++;
    if (wr_ack !== 1'b1) begin n_errors++; $display("FAIL basic_ack: got %0b want 1", wr_ack); end
    tick();
    set_in(1'b0, '0, '0, '0, 1'b0);
    tick();
    n_checks++;
    if ({mem_en, mem_adr, mem_data, count} !== {1'b1, 30'h4AD, 32'hDDCCBBAA, 3'd1}) begin
      n_errors++;
      $display("FAIL basic_load: en=%0b adr=%h data=%h count=%0d, required 1/4ad/ddccbbaa/1", mem_en, mem_adr, mem_data, count);
    end
    tick();
    tick();
    n_checks++;
    if ({mem_en, mem_adr, count} !== {1'b1, 30'h4AD, 3'd1}) begin
      n_errors++;
      $display("FAIL basic_hold: en=%0b adr=%h count=%0d, required 1/4ad/1", mem_en, mem_adr, count);
    end
    set_in(1'b0, '0, '0, '0, 1'b1);
    tick();
    n_checks++;
    if ({empty, mem_en, count} !== {1'b1, 1'b0, 3'd0}) begin
      n_errors++;
      $display("FAIL basic_retire: empty=%0b en=%0b count=%0d, required 1/0/0", empty, mem_en, count);
    end
    set_in(1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, AW'(32'h100 + i), $urandom, 4'hF, 1'b0);
      n_checks++;
      if (wr_ack !== (i < 4)) begin
        n_errors++;
        $display("FAIL fill_ack%0d: got %0b want %0b", i, wr_ack, (i < 4));
      end
      tick();
    end
    n_checks++;
    if ({full, count, mem_adr} !== {1'b1, 3'd4, 30'h100}) begin
      n_errors++;
      $display("FAIL fill_full: full=%0b count=%0d adr=%h, required 1/4/100", full, count, mem_adr);
    end
    set_in(1'b0, '0, '0, '0, 1'b1);
    tick();
    n_checks++;
    if ({full, count, mem_en, mem_adr} !== {1'b0, 3'd3, 1'b1, 30'h101}) begin
      n_errors++;
      $display("FAIL fill_b2b: full=%0b count=%0d en=%0b adr=%h, required 0/3/1/101", full, count, mem_en, mem_adr);
    end
    drain();
  endtask

  task automatic test_coalesce();
    set_in(1'b1, 30'h10, 32'hCAFEF00D, 4'hF, 1'b0);
    tick();
    set_in(1'b0, '0, '0, '0, 1'b0);
    tick();
    set_in(1'b1, 30'h20, 32'h000000AA, 4'b0001, 1'b0);
    tick();
    set_in(1'b1, 30'h20, 32'h0000BB00, 4'b0010, 1'b0);
    n_checks++;
    if (wr_ack !== 1'b1) begin n_errors++; $display("FAIL coal_ack: got %0b want 1", wr_ack); end
    tick();
    n_checks++;
    if ({count, mem_adr} !== {3'd2, 30'h10}) begin
      n_errors++;
      $display("FAIL coal_count: count=%0d adr=%h, required 2/10", count, mem_adr);
    end
    set_in(1'b1, 30'h10, 32'h00000055, 4'b0001, 1'b0);
    tick();
    n_checks++;
    if (count !== 3'd3) begin n_errors++; $display("FAIL coal_locked_alloc: count=%0d want 3", count); end
    set_in(1'b0, '0, '0, '0, 1'b1);
    tick();
    n_checks++;
    if ({mem_adr, mem_data, mem_byteen} !== {30'h20, 32'h0000BBAA, 4'b0011}) begin
      n_errors++;
      $display("FAIL coal_merge: adr=%h data=%h be=%b, required 20/0000bbaa/0011", mem_adr, mem_data, mem_byteen);
    end
    drain();
  endtask

  task automatic test_lookup();
    set_in(1'b1, 30'h30, 32'h11223344, 4'hF, 1'b0);
    tick();
    set_in(1'b0, '0, '0, '0, 1'b0);
    tick();
    set_in(1'b1, 30'h30, 32'h000000FF, 4'b0001, 1'b0);
    tick();
    set_in(1'b0, '0, '0, '0, 1'b0);
    lk_adr = 30'h30;
    #1;
    n_checks++;
    if ({count, lk_hit, lk_data, lk_byteen} !== {3'd2, 1'b1, 32'h112233FF, 4'hF}) begin
      n_errors++;
      $display("FAIL lookup_hit: count=%0d hit=%0b data=%h be=%b, required 2/1/112233ff/1111", count, lk_hit, lk_data, lk_byteen);
    end
    lk_adr = 30'h31;
    #1;
    n_checks++;
    if ({lk_hit, lk_byteen, lk_data} !== {1'b0, 4'h0, 32'h0}) begin
      n_errors++;
      $display("FAIL lookup_miss: hit=%0b be=%b data=%h, required 0/0000/0", lk_hit, lk_byteen, lk_data);
    end
    drain();
  endtask

  task automatic test_full_same_edge();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, AW'(32'h200 + i), $urandom, 4'hF, 1'b0);
      tick();
    end
    set_in(1'b1, 30'h202, 32'h77000000, 4'b1000, 1'b0);
    n_checks++;
    if ({full, wr_ack} !== 2'b11) begin
      n_errors++;
      $display("FAIL full_coalesce: full=%0b ack=%0b, required 1/1", full, wr_ack);
    end
    tick();
    set_in(1'b1, 30'h2FF, 32'h12345678, 4'hF, 1'b1);
    n_checks++;
    if (wr_ack !== 1'b0) begin n_errors++; $display("FAIL full_reject: ack=%0b want 0", wr_ack); end
    tick();
    n_checks++;
    if ({count, full} !== {3'd3, 1'b0}) begin
      n_errors++;
      $display("FAIL full_retire: count=%0d full=%0b, required 3/0", count, full);
    end
    set_in(1'b1, 30'h300, 32'hFFFFFFFF, 4'b0000, 1'b0);
    n_checks++;
    if (wr_ack !== 1'b1) begin n_errors++; $display("FAIL zero_be_ack: ack=%0b want 1", wr_ack); end
    tick();
    n_checks++;
    if (count !== 3'd3) begin n_errors++; $display("FAIL zero_be_count: count=%0d want 3", count); end
    drain();
  endtask

  task automatic test_async_reset();
    set_in(1'b1, 30'h400, 32'hA5A5A5A5, 4'hF, 1'b0);
    tick();
    set_in(1'b1, 30'h401, 32'h5A5A5A5A, 4'hF, 1'b0);
    tick();
    set_in(1'b0, '0, '0, '0, 1'b0);
    n_checks++;
    if (mem_en !== 1'b1) begin n_errors++; $display("FAIL areset_pre: mem_en=%0b want 1", mem_en); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({mem_en, empty, count} !== {1'b0, 1'b1, 3'd0}) begin
      n_errors++;
      $display("FAIL areset_now: en=%0b empty=%0b count=%0d, required 0/1/0", mem_en, empty, count);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    bit            e_hit;
    logic [DW-1:0] e_data;
    logic [NB-1:0] e_be;
    logic [NB-1:0] be;
    for (int c = 0; c < 600; c++) begin
      be = ($urandom_range(0, 7) == 0) ? 4'h0 : NB'($urandom_range(1, 15));
      set_in(1'($urandom_range(0, 1)), AW'(32'h40 + $urandom_range(0, 3)), $urandom, be,
             $urandom_range(0, 2) == 0);
      lk_adr = AW'(32'h40 + $urandom_range(0, 4));
      #1;
      model_lookup(lk_adr, e_hit, e_data, e_be);
      n_checks++;
      if (wr_ack !== model_ack()) begin
        n_errors++;
        $display("FAIL rnd_ack c=%0d: got %0b want %0b", c, wr_ack, model_ack());
      end
      n_checks++;
      if ({lk_hit, lk_byteen, lk_data} !== {e_hit, e_be, e_data}) begin
        n_errors++;
        $display("FAIL rnd_lookup c=%0d: hit=%0b be=%b data=%h, required %0b/%b/%h", c, lk_hit, lk_byteen, lk_data, e_hit, e_be, e_data);
      end
      tick();
      n_checks++;
      if ({mem_en, mem_adr, mem_byteen, mem_data & lane_mask(mem_byteen)} !==
          {m_busy, m_adr, m_be, m_data & lane_mask(m_be)}) begin
        n_errors++;
        $display("FAIL rnd_mem c=%0d: en=%0b adr=%h be=%b data=%h, required %0b/%h/%b/%h", c, mem_en, mem_adr, mem_byteen, mem_data, m_busy, m_adr, m_be, m_data);
      end
      n_checks++;
      if ({count, full, empty} !== {3'(q.size()), q.size() == DEPTH, q.size() == 0}) begin
        n_errors++;
        $display("FAIL rnd_status c=%0d: count=%0d full=%0b empty=%0b, required count=%0d", c, count, full, empty, q.size());
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_coalesce();
    test_lookup();
    test_full_same_edge();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/write_buffer_coalesce.md
Name: write_buffer_coalesce

Overview:
- Parametrised posted-write buffer between the data cache's memory-side write path and the main-memory arbiter.
- Successor to the fixed 4-entry write buffer, with four additions: configurable depth and widths, byte-lane write coalescing, a read-lookup port for forwarding, and explicit full/empty/count status.
- Writes drain to memory in FIFO order of allocation, one outstanding memory transaction at a time.

Parameters:
DEPTH, 4, number of entries; power of two, 2..32
AW, 30, word-address width
DW, 32, data width; multiple of 8; NB = DW/8 byte lanes
COALESCE, 1, 1 = merge writes to an address already buffered; 0 = always allocate

Ports:
clk  input  1  clock; all state on rising edge
reset  input  1  asynchronous active-high reset
wr_adr  input  AW  write word address
wr_data  input  DW  write data
wr_byteen  input  NB  write byte enables
wr_en  input  1  write request
wr_ack  output  1  combinational; write accepted at this edge
lk_adr  input  AW  lookup address
lk_hit  output  1  combinational; some buffered entry matches lk_adr
lk_data  output  DW  combinational; merged buffered bytes for lk_adr
lk_byteen  output  NB  combinational; lanes of lk_data that are valid
mem_adr  output  AW  registered memory address
mem_data  output  DW  registered memory data
mem_byteen  output  NB  registered memory byte enables
mem_en  output  1  registered memory write request
mem_done  input  1  memory completed the current request; sampled only while mem_en=1
full  output  1  all DEPTH entries valid
empty  output  1  no valid entries
count  output  $clog2(DEPTH+1)  number of valid entries

Behaviour:
Reset (asynchronous, while reset=1):
- All entries invalid; head and tail pointers 0.
- mem_en=0; mem_adr, mem_data, mem_byteen = 0.
- count=0, empty=1, full=0.
- Asserting reset mid-transaction discards all pending writes, including the one in flight.

Entry state:
- Each entry holds adr, data, byteen and valid.
- The head entry is "locked" from the cycle it is loaded onto mem_* until it retires.

Write acceptance (all evaluated combinationally in the cycle):
- wr_en=1 and wr_byteen=0: wr_ack=1; no state change.
- COALESCE=1 and wr_adr matches a valid, unlocked entry: wr_ack=1 even when full. For each set lane, that entry's data byte is replaced and its byteen bit is set; count is unchanged.
- Otherwise: wr_ack = ~full. On ack, the tail entry is written and valid is set, tail advances modulo DEPTH, count increments.
- Uniqueness: at most one unlocked entry per address. A second, locked entry may hold the same address.

Drain:
- Load: when mem_en=0 and a valid head exists, the next edge loads the head onto mem_*, sets mem_en=1 and locks the head.
- Hold: mem_* stay stable until mem_done=1 is sampled.
- Retire: on that edge the head is invalidated, head advances and count decrements. If another valid entry exists, it is loaded at the same edge (back-to-back, mem_en stays 1); otherwise mem_en=0.
- Latency: a write into an empty buffer reaches mem_en=1 one cycle after acceptance.

Simultaneous events:
- Accept and retire on the same edge: count is unchanged; full deasserts only after the edge.
- A write arriving while full is not accepted that cycle, even if a retire occurs at the same edge. The exception is a coalesce hit, which is accepted.

Lookup:
- lk_hit = OR over valid entries of (adr == lk_adr), locked head included.
- lk_data and lk_byteen are a byte-wise merge of all matching entries. For each lane, the youngest entry with that byteen bit set supplies the byte; lanes with no such entry have lk_byteen=0 and lk_data=0.
- Lookup reflects state before the current edge; a write in the same cycle is not forwarded.

Status:
- full = (count == DEPTH); empty = (count == 0); both derived from registered state.

Test Plan:
- Reset, then write adr=0x4AD data=0xDDCCBBAA byteen=1111 with mem_done held low. Required: wr_ack=1; next cycle mem_en=1, mem_adr=0x4AD, mem_data=0xDDCCBBAA; count=1 until mem_done pulse, then empty=1, mem_en=0.
- DEPTH=4, mem_done=0: issue 5 writes to distinct addresses. Required: first 4 acked, 5th wr_ack=0, full=1, count=4. Then pulse mem_done once: full=0, count=3, next head on mem_* back-to-back.
- COALESCE=1, head locked on adr 0x10. Write 0x20/0x000000AA/0001, then 0x20/0x0000BB00/0010. Required: count=2, and after 0x10 retires, mem_data=0x0000BBAA with mem_byteen=0011. A write to 0x10 while 0x10 is locked allocates a new entry.
- Lookup: entries 0x30/0x11223344/1111 (older) and 0x30/0x000000FF/0001 (younger, locked case). Required: lk_hit=1, lk_data=0x112233FF, lk_byteen=1111; lk_adr=0x31 gives lk_hit=0, lk_byteen=0000.
- Full buffer, same-edge write and mem_done. Required: non-coalescing write rejected, count 4→3. Write with byteen=0000 is acked with no count change.
- Assert reset asynchronously mid-drain with mem_en=1. Required: mem_en=0, empty=1, count=0 immediately, without waiting for a clk edge.
